// File: rtl/fp16_pkg.sv
// Shared FP16 constants, word layout and the BCD-to-FP16 sequencer states.
package fp16_pkg;

  localparam int unsigned FP16_W    = 16;
  localparam int unsigned EXP_W     = 5;
  localparam int unsigned MANT_W    = 10;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned FP16_BIAS = 15;

  localparam logic [FP16_W-1:0] FP16_ZERO    = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_POS_INF = 16'h7C00;
  localparam logic [FP16_W-1:0] FP16_QNAN    = 16'h7E00;
  localparam logic [FP16_W-1:0] FP16_MAX     = 16'h7BFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp16_t;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    NORM,
    ROUND,
    DONE
  } b2f_state_t;

  // True when the nibble is a legal decimal digit.
  function automatic logic is_bcd_digit(input logic [NIB_W-1:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/fp16_round_pack.sv
// Round-to-nearest-even and pack of a normalised magnitude into an FP16 word.
// The leading one is implicit: only the bits below it are passed in as frac.
module fp16_round_pack
  import fp16_pkg::*;
#(
  parameter int unsigned BIN_W = 17,
  parameter int unsigned P_W   = 5
) (
  input  logic [BIN_W-2:0]  frac,
  input  logic [P_W-1:0]    p,
  input  logic              neg,
  output logic [FP16_W-1:0] result_c,
  output logic              ovf_c
);

  localparam int unsigned GUARD_BIT = BIN_W - 2 - MANT_W;
  localparam int unsigned EXPS_W    = P_W + 2;

  logic [MANT_W-1:0] mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [MANT_W:0]   mant_rnd;
  logic [EXPS_W-1:0] exp_sum;
  fp16_t             word;

  // Mantissa rounding, exponent bias and overflow-to-infinity selection.
  always_comb begin
    mant     = frac[BIN_W-2 -: MANT_W];
    guard    = frac[GUARD_BIT];
    sticky   = |frac[GUARD_BIT-1:0];
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + (MANT_W+1)'(round_up);
    exp_sum  = EXPS_W'(p) + EXPS_W'(FP16_BIAS) + EXPS_W'(mant_rnd[MANT_W]);
    ovf_c    = (exp_sum >= EXPS_W'(31));
    word.sign = neg;
    if (ovf_c) begin
      word.exp  = {EXP_W{1'b1}};
      word.mant = '0;
    end else begin
      word.exp  = exp_sum[EXP_W-1:0];
      word.mant = mant_rnd[MANT_W-1:0];
    end
    result_c = word;
  end

endmodule

// File: rtl/bcd_to_fp16.sv
// Keypad BCD integer to FP16 converter: digit MAC, normalise, round/pack.
module bcd_to_fp16
  import fp16_pkg::*;
#(
  parameter int unsigned DIGITS = 5,
  parameter int unsigned BIN_W  = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DIGITS*4-1:0]     bcd_in,
  input  logic                    neg,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             result,
  output logic                    ovf,
  output logic                    err
);

  localparam int unsigned BCD_W = DIGITS * NIB_W;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned P_W   = $clog2(BIN_W);

  b2f_state_t        state_q, state_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic [BIN_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [P_W-1:0]    p_q, p_d;
  logic [15:0]       result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              any_bad;
  logic [NIB_W-1:0]  digit;
  logic [BIN_W-1:0]  mac;
  logic [15:0]       rp_result;
  logic              rp_ovf;

  fp16_round_pack #(
    .BIN_W (BIN_W),
    .P_W   (P_W)
  ) u_round_pack (
    .frac     (acc_q[BIN_W-2:0]),
    .p        (p_q),
    .neg      (neg_q),
    .result_c (rp_result),
    .ovf_c    (rp_ovf)
  );

  // Digit validity of the live input, consulted only when a start is accepted.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!is_bcd_digit(bcd_in[i*NIB_W +: NIB_W])) any_bad = 1'b1;
    end
  end

  // acc*10 + next digit; digits are consumed from the top of a shift register.
  always_comb begin
    digit = bcd_q[BCD_W-1 -: NIB_W];
    mac   = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    p_d      = p_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d = bcd_in;
          neg_d = neg;
          acc_d = '0;
          idx_d = IDX_W'(DIGITS - 1);
          ovf_d = 1'b0;
          err_d = 1'b0;
          if (any_bad) begin
            result_d = FP16_QNAN;
            err_d    = 1'b1;
            state_d  = DONE;
          end else begin
            state_d  = CONV;
          end
        end
      end
      CONV: begin
        acc_d = mac;
        bcd_d = bcd_q << NIB_W;
        if (idx_q == '0) begin
          if (mac == '0) begin
            // Zero is always +0 regardless of the entered sign.
            result_d = FP16_ZERO;
            state_d  = DONE;
          end else begin
            p_d     = P_W'(BIN_W - 1);
            state_d = NORM;
          end
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      NORM: begin
        if (acc_q[BIN_W-1]) begin
          state_d = ROUND;
        end else begin
          acc_d = acc_q << 1;
          p_d   = p_q - 1'b1;
        end
      end
      ROUND: begin
        result_d = rp_result;
        ovf_d    = rp_ovf;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // done trails the DONE state by one cycle; busy drops in that same cycle.
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      idx_q    <= '0;
      p_q      <= '0;
      result_q <= FP16_ZERO;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      p_q      <= p_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_to_fp16.sv
// Directed bench for bcd_to_fp16: values, rounding, overflow, latency, handshake.
module tb_bcd_to_fp16;

  logic        clk;
  logic        reset;
  logic [19:0] bcd_in;
  logic        neg;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovf;
  logic        err;

  int tests;
  int fails;

  bcd_to_fp16 #(
    .DIGITS (5),
    .BIN_W  (17)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bcd_in (bcd_in),
    .neg    (neg),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One conversion: start, scramble inputs after acceptance, optionally re-pulse
  // start after poke_cyc observed cycles, then check result, flags and latency.
  task automatic conv(input string tag, input logic [19:0] bcd, input logic sgn,
                      input logic [15:0] exp_res, input logic exp_ovf,
                      input logic exp_err, input int exp_lat, input int poke_cyc);
    int cyc;
    logic seen;
    bcd_in = bcd;
    neg    = sgn;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    bcd_in = 20'h98765;
    neg    = ~sgn;
    chk({tag, ":busy_after_accept"}, 32'(busy), 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (cyc < 60 && !seen) begin
      start = (poke_cyc != 0) && (cyc == poke_cyc);
      @(posedge clk); #1;
      cyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, ":done_seen"}, 32'(seen), 32'd1);
    chk({tag, ":latency"},   32'(cyc), 32'(exp_lat));
    chk({tag, ":result"},    32'(result), 32'(exp_res));
    chk({tag, ":ovf"},       32'(ovf), 32'(exp_ovf));
    chk({tag, ":err"},       32'(err), 32'(exp_err));
    chk({tag, ":busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, ":done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, ":idle_after"},     32'(busy), 32'd0);
    chk({tag, ":result_held"},    32'(result), 32'(exp_res));
  endtask

  initial begin
    logic seen_done;
    tests  = 0;
    fails  = 0;
    reset  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    neg    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset:result", 32'(result), 32'h0);
    chk("reset:busy",   32'(busy),   32'd0);
    chk("reset:done",   32'(done),   32'd0);
    chk("reset:ovf",    32'(ovf),    32'd0);
    chk("reset:err",    32'(err),    32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Main values, rounding and overflow boundary.
    conv("one",      20'h00001, 1'b0, 16'h3C00, 1'b0, 1'b0, 24, 0);
    conv("d12345",   20'h12345, 1'b0, 16'h7207, 1'b0, 1'b0, 11, 0);
    conv("tie_down", 20'h02049, 1'b0, 16'h6800, 1'b0, 1'b0, 13, 0);
    conv("tie_up",   20'h02051, 1'b0, 16'h6802, 1'b0, 1'b0, 13, 0);
    conv("neg3",     20'h00003, 1'b1, 16'hC200, 1'b0, 1'b0, 23, 0);
    conv("max",      20'h65504, 1'b0, 16'h7BFF, 1'b0, 1'b0, 9, 0);
    conv("below_inf",20'h65519, 1'b0, 16'h7BFF, 1'b0, 1'b0, 9, 0);
    conv("to_inf",   20'h65520, 1'b0, 16'h7C00, 1'b1, 1'b0, 9, 0);
    conv("neg_inf",  20'h99999, 1'b1, 16'hFC00, 1'b1, 1'b0, 8, 0);

    // Reset mid-NORM: aborts without done and clears the held result/flags.
    bcd_in = 20'h00001;
    neg    = 1'b0;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    seen_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    reset = 1'b0;
    #2;
    chk("rst_mid:no_done", 32'(seen_done), 32'd0);
    chk("rst_mid:result",  32'(result), 32'h0);
    chk("rst_mid:busy",    32'(busy),   32'd0);
    chk("rst_mid:done",    32'(done),   32'd0);
    chk("rst_mid:ovf",     32'(ovf),    32'd0);
    chk("rst_mid:err",     32'(err),    32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid:idle_busy", 32'(busy), 32'd0);
    chk("rst_mid:idle_done", 32'(done), 32'd0);

    conv("after_rst", 20'h00001, 1'b0, 16'h3C00, 1'b0, 1'b0, 24, 0);

    // Zero and invalid digit.
    conv("zero_neg", 20'h00000, 1'b1, 16'h0000, 1'b0, 1'b0, 6, 0);
    conv("bad_digit",20'h0A123, 1'b0, 16'h7E00, 1'b0, 1'b1, 1, 0);

    // Handshake: start while busy, start in DONE state, back-to-back accept.
    conv("poke_busy", 20'h00003, 1'b0, 16'h4200, 1'b0, 1'b0, 23, 5);
    conv("poke_done", 20'h02051, 1'b0, 16'h6802, 1'b0, 1'b0, 13, 12);
    conv("b2b",       20'h00001, 1'b1, 16'hBC00, 1'b0, 1'b0, 24, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
